// File: rtl/long_pkg.sv
// long_pkg: limb/operand types and scheduler states shared by the long-arithmetic schedulers.
package long_pkg;
  localparam int WIDTH = 16;
  localparam int L = 4;
  localparam int MAX = 10000;
  typedef logic [WIDTH-1:0] limb_t;
  typedef limb_t [L-1:0] long_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} sched_state_t;
endpackage

// File: rtl/long_sub_sched_if.sv
// long_sub_sched_if: requester-side job bus of the shared subtractor scheduler.
interface long_sub_sched_if
  import long_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  long_t [N_REQ-1:0] req_a;
  long_t [N_REQ-1:0] req_b;
  logic [N_REQ-1:0] gnt;
  logic done;
  logic [ID_W-1:0] done_id;
  long_t result;
  logic err;
  logic busy;
  modport master (output req, req_a, req_b, input gnt, done, done_id, result, err, busy);
  modport slave (input req, req_a, req_b, output gnt, done, done_id, result, err, busy);
endinterface

// File: rtl/long_sub_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);
  logic [ID_W-1:0] k;
  always_comb begin
    idx = '0;
    k = '0;
    // Walk the ring backwards so the last hit is the nearest one from ptr.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr) + i) % N_REQ);
      if (req[k]) idx = k;
    end
    grant = (|req) ? (N_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/long_sub_sched.sv
// long_sub_sched: round-robin sharing of one sub_long subtractor among N_REQ requesters.
module long_sub_sched
  import long_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic             ck,
  input  logic             rst,
  long_sub_sched_if.slave  rq,
  output long_t            sub_a,
  output long_t            sub_b,
  output logic             sub_rst,
  input  logic             sub_finish,
  input  long_t            sub_c
);
  localparam int CNT_W = $clog2(L + 5);
  sched_state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, did_q, did_d, arb_idx;
  logic [N_REQ-1:0] gnt_q, gnt_d, arb_gnt;
  long_t a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d, take;
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(rq.req), .ptr(ptr_q), .grant(arb_gnt), .idx(arb_idx)
  );
  // DONE arbitrates too, so back-to-back jobs cost L+5 cycles.
  assign take = (state_q == IDLE || state_q == DONE) && |rq.req;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    did_d = did_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    gnt_d = '0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (take) begin
      gnt_d = arb_gnt;
      id_d = arb_idx;
      a_d = rq.req_a[arb_idx];
      b_d = rq.req_b[arb_idx];
      ptr_d = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      state_d = LAUNCH;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == LAUNCH) begin
      cnt_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (sub_finish || cnt_q == CNT_W'(L + 4)) begin
        done_d = 1'b1;
        did_d = id_q;
        err_d = !sub_finish;
        res_d = sub_finish ? sub_c : res_q;
        state_d = DONE;
      end
    end
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      did_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      did_q <= did_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign rq.gnt = gnt_q;
  assign rq.done = done_q;
  assign rq.done_id = did_q;
  assign rq.result = res_q;
  assign rq.err = err_q;
  assign rq.busy = state_q != IDLE;
  assign sub_a = a_q;
  assign sub_b = b_q;
  assign sub_rst = state_q != RUN;
endmodule

// File: tb/tb_long_sub_sched.sv
// tb_long_sub_sched: directed jobs against a behavioural job-timeline model and a limb-serial sub_long stand-in.
module tb_long_sub_sched;
  import long_pkg::*;
  localparam int N = 4;
  logic ck = 1'b0;
  logic rst = 1'b0;
  long_t sub_a, sub_b;
  long_t sub_c = '0;
  logic sub_rst, sub_finish;
  long_sub_sched_if #(.N_REQ(N)) bus ();
  long_sub_sched #(.N_REQ(N)) dut (
    .ck(ck), .rst(rst), .rq(bus), .sub_a(sub_a), .sub_b(sub_b),
    .sub_rst(sub_rst), .sub_finish(sub_finish), .sub_c(sub_c)
  );
  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;
  bit force_to = 0;

  function automatic long_t mk(input int l3, input int l2, input int l1, input int l0);
    long_t r;
    r[3] = limb_t'(l3);
    r[2] = limb_t'(l2);
    r[1] = limb_t'(l1);
    r[0] = limb_t'(l0);
    return r;
  endfunction

  function automatic long_t unit_sub(input long_t a, input long_t b);
    long_t r;
    int br = 0;
    for (int i = 0; i < L; i++) begin
      int d = int'(a[i]) - int'(b[i]) - br;
      br = (d < 0) ? 1 : 0;
      if (d < 0) d += MAX;
      r[i] = limb_t'(d);
    end
    return r;
  endfunction

  function automatic longint val(input long_t x);
    longint v = 0;
    for (int i = L - 1; i >= 0; i--) v = v * MAX + longint'(x[i]);
    return v;
  endfunction

  function automatic long_t model_diff(input long_t a, input long_t b);
    longint md = 1;
    longint d;
    long_t r;
    for (int i = 0; i < L; i++) md = md * MAX;
    d = val(a) - val(b);
    if (d < 0) d += md;
    for (int i = 0; i < L; i++) begin
      r[i] = limb_t'(d % MAX);
      d = d / MAX;
    end
    return r;
  endfunction

  // Stand-in for sub_long: finishes on the 6th clock out of reset, unless the bench holds finish low.
  int ucnt = 0;
  logic ufin = 1'b0;
  always @(posedge ck) begin
    if (sub_rst) begin
      ucnt <= 0;
      ufin <= 1'b0;
    end else begin
      ucnt <= ucnt + 1;
      if (ucnt == L + 1) begin
        ufin <= 1'b1;
        sub_c <= unit_sub(sub_a, sub_b);
      end
    end
  end
  assign sub_finish = ufin && !force_to;

  // Job-timeline model: a grant starts a job whose done lands L+4 (or L+6 on timeout) cycles later.
  logic [N-1:0] e_gnt = '0;
  logic e_done = 0, e_err = 0, e_busy = 0, e_srst = 1;
  logic [1:0] e_id = '0;
  long_t e_res = '0, m_a = '0, m_b = '0, m_c = '0;
  int m_left = 0, m_ptr = 0, m_id = 0, w;
  bit m_to = 0;
  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      e_gnt = '0; e_done = 0; e_err = 0; e_busy = 0; e_srst = 1; e_id = '0;
      e_res = '0; m_a = '0; m_b = '0; m_left = 0; m_ptr = 0;
    end else begin
      e_gnt = '0; e_done = 0; e_err = 0;
      if (m_left == 0) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && bus.req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        if (w >= 0) begin
          e_gnt = N'(1 << w);
          m_id = w;
          m_ptr = (w + 1) % N;
          m_a = bus.req_a[w];
          m_b = bus.req_b[w];
          m_c = model_diff(m_a, m_b);
          m_to = force_to;
          m_left = force_to ? L + 6 : L + 4;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          e_done = 1; e_id = 2'(m_id); e_err = m_to;
          if (!m_to) e_res = m_c;
        end
      end
      e_busy = (e_gnt != 0) || (m_left > 0) || e_done;
      e_srst = !((m_left > 0) && (e_gnt == 0));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ck) if (cmp_en) begin
    chk("gnt", 64'(bus.gnt), 64'(e_gnt));
    chk("done", 64'(bus.done), 64'(e_done));
    chk("err", 64'(bus.err), 64'(e_err));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("sub_rst", 64'(sub_rst), 64'(e_srst));
    chk("result", bus.result, e_res);
    if (e_done) chk("done_id", 64'(bus.done_id), 64'(e_id));
    if (e_busy) begin
      chk("sub_a", sub_a, m_a);
      chk("sub_b", sub_b, m_b);
    end
  end

  // kind 0 waits for any gnt, kind 1 for done; c counts negedges until it is seen.
  task automatic wait_ev(input int kind, input int max, output int c, output bit ok);
    c = 0;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge ck);
      c++;
      if ((kind == 0 && bus.gnt != 0) || (kind == 1 && bus.done)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic job(input int id, input long_t a, input long_t b, input int lat,
                     input long_t res, input logic er);
    int c;
    bit ok;
    @(negedge ck); #1;
    bus.req_a[id] = a;
    bus.req_b[id] = b;
    bus.req[id] = 1'b1;
    wait_ev(0, 12, c, ok);
    chk("job_gnt_seen", 64'(ok), 64'(1));
    chk("job_gnt", 64'(bus.gnt), 64'(1 << id));
    #1;
    bus.req[id] = 1'b0;
    bus.req_a[id] = long_t'({$urandom, $urandom});
    bus.req_b[id] = long_t'({$urandom, $urandom});
    wait_ev(1, 14, c, ok);
    chk("job_done_seen", 64'(ok), 64'(1));
    chk("job_latency", 64'(c), 64'(lat));
    chk("job_done_id", 64'(bus.done_id), 64'(id));
    chk("job_err", 64'(bus.err), 64'(er));
    chk("job_result", bus.result, res);
  endtask

  task automatic pulse_reset();
    @(negedge ck); #2;
    rst = 1'b0;
    repeat (2) @(negedge ck);
    #1 rst = 1'b1;
  endtask

  initial begin
    int c;
    bit ok;
    int ord[5] = '{0, 1, 2, 3, 0};
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge ck);
    cmp_en = 1;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_sub_rst", 64'(sub_rst), 64'(1));
    #1 rst = 1'b1;
    job(2, mk(0, 0, 1, 0), mk(0, 0, 0, 1), 8, mk(0, 0, 0, 9999), 1'b0);
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = mk(0, 0, i + 1, i);
      bus.req_b[i] = mk(0, 0, 0, i + 3);
    end
    @(negedge ck); #1;
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ev(0, 12, c, ok);
      chk("rr_gnt_seen", 64'(ok), 64'(1));
      chk("rr_order", 64'(bus.gnt), 64'(1 << ord[k]));
      if (k > 0) chk("rr_spacing", 64'(c), 64'(L + 5));
    end
    #1 bus.req = '0;
    wait_ev(1, 14, c, ok);
    chk("rr_last_done", 64'(ok), 64'(1));
    job(0, mk(1, 0, 0, 0), mk(0, 0, 0, 1), 8, mk(0, 9999, 9999, 9999), 1'b0);
    job(1, mk(1234, 5678, 9, 0), mk(1234, 5678, 9, 0), 8, mk(0, 0, 0, 0), 1'b0);
    force_to = 1;
    job(3, mk(0, 0, 0, 5), mk(0, 0, 0, 1), 10, mk(0, 0, 0, 0), 1'b1);
    force_to = 0;
    job(2, mk(0, 0, 5, 5), mk(0, 0, 2, 7), 8, mk(0, 0, 2, 9998), 1'b0);
    @(negedge ck); #1;
    bus.req_a[0] = mk(0, 0, 0, 7);
    bus.req_b[0] = mk(0, 0, 0, 2);
    bus.req[0] = 1'b1;
    wait_ev(0, 12, c, ok);
    chk("abort_gnt_seen", 64'(ok), 64'(1));
    #1 bus.req[0] = 1'b0;
    repeat (3) @(negedge ck);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_sub_rst", 64'(sub_rst), 64'(1));
    chk("abort_result", bus.result, 64'(0));
    chk("abort_sub_a", sub_a, 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    repeat (3) @(negedge ck);
    #1 rst = 1'b1;
    job(3, mk(0, 2, 0, 0), mk(0, 0, 0, 3), 8, mk(0, 1, 9999, 9997), 1'b0);
    repeat (3) @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule
